doce_tx_framer_mc: RTL



---
 rtl/doce_tx_framer_mc.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/doce_tx_framer_mc.sv
// doce_tx_framer_mc
// Multi-channel DoCE Tx framer. Channels are arbitrated round-robin and held
// for a whole packet. The destination node id is looked up in an internal
// MAC table. A hit sends one header beat followed by the payload beats of the
// granted channel. A miss drains the packet silently and bumps drop_cnt.

module doce_tx_framer_mc #(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_WIDTH = 16,
    parameter int          NODE_W     = 4,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH*DATA_WIDTH*8-1:0] s_axis_tdata,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_axis_tkeep,
    input  logic [NUM_CH*NODE_W-1:0]       s_axis_tuser,
    input  logic [NUM_CH-1:0]              s_axis_tlast,
    input  logic [NUM_CH-1:0]              s_axis_tvalid,
    output logic [NUM_CH-1:0]              s_axis_tready,
    input  logic                           tbl_wr_en,
    input  logic [NODE_W-1:0]              tbl_wr_addr,
    input  logic [47:0]                    tbl_wr_mac,
    input  logic                           tbl_wr_vld,
    input  logic [47:0]                    doce_mac_addr,
    output logic [DATA_WIDTH*8-1:0]        m_axis_tdata,
    output logic [DATA_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [31:0]                    tx_frame_cnt,
    output logic [31:0]                    drop_cnt
);

    localparam int DW    = DATA_WIDTH * 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << NODE_W;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_HDR     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_DROP    = 3'd4;

    logic [2:0]        r_state;
    logic [CH_W-1:0]   r_grant;
    logic [NODE_W-1:0] r_node;
    logic [CH_W-1:0]   r_rrPtr;
    logic [31:0]       r_txCnt;
    logic [31:0]       r_dropCnt;
    logic [47:0]       r_dstMac;
    logic [DEPTH-1:0]  r_tblVld;
    logic [47:0]       r_tblMac [DEPTH];

    logic              w_reqAny;
    logic [CH_W-1:0]   w_reqIdx;
    int                w_scanIdx;
    logic [NODE_W-1:0] w_reqUser;
    logic [CH_W-1:0]   w_nextPtr;
    logic [DW-1:0]     w_hdr;
    logic [DW-1:0]     w_gData;
    logic [DATA_WIDTH-1:0] w_gKeep;
    logic              w_gLast;
    logic              w_gValid;

    assign w_reqUser = s_axis_tuser[int'(w_reqIdx)*NODE_W +: NODE_W];
    assign w_gData   = s_axis_tdata[int'(r_grant)*DW +: DW];
    assign w_gKeep   = s_axis_tkeep[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    assign w_gLast   = s_axis_tlast[r_grant];
    assign w_gValid  = s_axis_tvalid[r_grant];
    assign w_nextPtr = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

    assign tx_frame_cnt = r_txCnt;
    assign drop_cnt     = r_dropCnt;

    // Round-robin pick: first requesting channel at or after the pointer
    always_comb begin
        w_reqAny  = 1'b0;
        w_reqIdx  = '0;
        w_scanIdx = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_scanIdx = int'(r_rrPtr) + k;
            if (w_scanIdx >= NUM_CH) begin
                w_scanIdx = w_scanIdx - NUM_CH;
            end
            if (s_axis_tvalid[w_scanIdx]) begin
                w_reqAny = 1'b1;
                w_reqIdx = CH_W'(w_scanIdx);
            end
        end
    end

    // Header beat: dst MAC, src MAC, EtherType, channel, node, zero padding
    always_comb begin
        w_hdr = '0;
        for (int i = 0; i < 6; i++) begin
            w_hdr[i*8 +: 8]     = r_dstMac[(5-i)*8 +: 8];
            w_hdr[(6+i)*8 +: 8] = doce_mac_addr[(5-i)*8 +: 8];
        end
        w_hdr[96 +: 8]  = ETHERTYPE[15:8];
        w_hdr[104 +: 8] = ETHERTYPE[7:0];
        w_hdr[112 +: 8] = 8'(r_grant);
        w_hdr[120 +: 8] = 8'(r_node);
    end

    // Output mux and per-channel ready, driven purely by the current state
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ST_HDR: begin
                m_axis_tdata  = w_hdr;
                m_axis_tkeep  = '1;
                m_axis_tvalid = 1'b1;
            end
            ST_PAYLOAD: begin
                m_axis_tdata           = w_gData;
                m_axis_tkeep           = w_gKeep;
                m_axis_tlast           = w_gLast;
                m_axis_tvalid          = w_gValid;
                s_axis_tready[r_grant] = m_axis_tready;
            end
            ST_DROP: begin
                s_axis_tready[r_grant] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Table MAC storage; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (tbl_wr_en) begin
            r_tblMac[tbl_wr_addr] <= tbl_wr_mac;
        end
    end

    // Table valid bits, cleared on reset so every lookup misses until written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tblVld <= '0;
        end else if (tbl_wr_en) begin
            r_tblVld[tbl_wr_addr] <= tbl_wr_vld;
        end
    end

    // Framing FSM with grant latch, round-robin pointer and statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_node    <= '0;
            r_rrPtr   <= '0;
            r_txCnt   <= '0;
            r_dropCnt <= '0;
            r_dstMac  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_reqAny) begin
                        r_grant <= w_reqIdx;
                        r_node  <= w_reqUser;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_dstMac <= r_tblMac[r_node];
                    r_state  <= r_tblVld[r_node] ? ST_HDR : ST_DROP;
                end
                ST_HDR: begin
                    if (m_axis_tready) begin
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_gValid && m_axis_tready && w_gLast) begin
                        r_state <= ST_IDLE;
                        r_txCnt <= r_txCnt + 32'd1;
                        r_rrPtr <= w_nextPtr;
                    end
                end
                ST_DROP: begin
                    if (w_gValid && w_gLast) begin
                        r_state   <= ST_IDLE;
                        r_dropCnt <= r_dropCnt + 32'd1;
                        r_rrPtr   <= w_nextPtr;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
